// File: rtl/payload_rd_arbiter_pkg.sv
// Shared payload-bus types and arbiter state encoding.
//   Address_t / ByteCount_t / Data_t : payload read bus fields
//   RdArbState_t                     : read arbiter FSM states
//   idx_w()                          : index width for a requester count (min 1 bit)
package payload_rd_arbiter_pkg;

  localparam int ADDRESS_W    = 32;
  localparam int DATA_W       = 64;
  localparam int BYTE_COUNT_W = 4;

  typedef logic [ADDRESS_W-1:0]    Address_t;
  typedef logic [DATA_W-1:0]       Data_t;
  typedef logic [BYTE_COUNT_W-1:0] ByteCount_t;

  typedef enum logic [1:0] {
    RDARB_IDLE,
    RDARB_GRANT,
    RDARB_BUSY
  } RdArbState_t;

  // A single requester still needs a 1-bit index so vectors never collapse to zero width.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/payload_rd_arbiter_rr_pick.sv
// Combinational round-robin picker: selects the first asserted request at or
// after ptr, wrapping modulo NUM_REQ.
//   req     in  NUM_REQ  request vector
//   ptr     in  REQ_W    starting position (must be < NUM_REQ)
//   one_hot out NUM_REQ  one-hot winner (0 when nothing requests)
//   index   out REQ_W    winner index
//   any     out 1        at least one request present
module rr_pick
  import payload_rd_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int REQ_W   = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [REQ_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] one_hot,
  output logic [REQ_W-1:0]   index,
  output logic               any
);

  localparam int CW = REQ_W + 1;

  // One spare bit so ptr + offset cannot overflow before the wrap subtract.
  logic [CW-1:0] cand;

  always_comb begin
    one_hot = '0;
    index   = '0;
    any     = 1'b0;
    cand    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, ptr} + CW'(i);
      if (cand >= CW'(NUM_REQ)) begin
        cand = cand - CW'(NUM_REQ);
      end
      if (!any && req[cand[REQ_W-1:0]]) begin
        any                      = 1'b1;
        index                    = cand[REQ_W-1:0];
        one_hot[cand[REQ_W-1:0]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/payload_rd_arbiter.sv
// Shares one payload-memory read port between NUM_REQ read clients. Grants
// round-robin per packet and holds the grant from the first beat until the
// slave returns memIsLast.
// Optional watchdog: define PAYLOAD_RD_ARB_WDOG_EN to abort a packet that runs
// WDOG_CYCLES BUSY cycles without memIsLast (sticky wdogErr, forced rspIsLast).
//   clk, rst_n         clock / async active-low reset
//   reqValid           per-client packet read request
//   reqIsFirst         per-client first-beat marker
//   reqAddress         per-client beat address
//   reqIsDestructive   per-client free-on-read flag
//   reqGrant           registered one-hot grant
//   rspData            slave data, broadcast
//   rspByteCount       slave byte count, broadcast
//   rspIsLast          slave isLast, routed to the granted client only
//   memIsFirst, memAddress, memIsDestructive  to slave (0 when nobody granted)
//   memData, memByteCount, memIsLast          from slave
//   wdogErr            sticky watchdog error (0 without the watchdog)
//
// state       | meaning
// RDARB_IDLE  | no owner; pick next requester from rr_ptr
// RDARB_GRANT | first cycle of ownership; memIsLast ignored
// RDARB_BUSY  | owner streams beats until memIsLast (or watchdog)
module payload_rd_arbiter
  import payload_rd_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int REQ_W       = idx_w(NUM_REQ),
  parameter int WDOG_CYCLES = 256
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     reqValid,
  input  logic [NUM_REQ-1:0]     reqIsFirst,
  input  Address_t [NUM_REQ-1:0] reqAddress,
  input  logic [NUM_REQ-1:0]     reqIsDestructive,
  output logic [NUM_REQ-1:0]     reqGrant,
  output Data_t                  rspData,
  output ByteCount_t             rspByteCount,
  output logic [NUM_REQ-1:0]     rspIsLast,
  output logic                   memIsFirst,
  output Address_t               memAddress,
  output logic                   memIsDestructive,
  input  Data_t                  memData,
  input  ByteCount_t             memByteCount,
  input  logic                   memIsLast,
  output logic                   wdogErr
);

  RdArbState_t        state_q, state_d;
  logic [NUM_REQ-1:0] grant_q;
  logic [REQ_W-1:0]   win_q;
  logic [REQ_W-1:0]   rr_ptr_q;
  logic [REQ_W-1:0]   next_ptr;

  logic [NUM_REQ-1:0] pick_one_hot;
  logic [REQ_W-1:0]   pick_index;
  logic               pick_any;

  logic               take_grant;
  logic               pkt_end;
  logic               wdog_expire;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .REQ_W   (REQ_W)
  ) u_rr_pick (
    .req     (reqValid),
    .ptr     (rr_ptr_q),
    .one_hot (pick_one_hot),
    .index   (pick_index),
    .any     (pick_any)
  );

  assign take_grant = (state_q == RDARB_IDLE) && pick_any;
  assign pkt_end    = (state_q == RDARB_BUSY) && (memIsLast || wdog_expire);
  assign next_ptr   = (win_q == REQ_W'(NUM_REQ - 1)) ? '0 : win_q + REQ_W'(1);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RDARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      RDARB_IDLE:  if (pick_any) state_d = RDARB_GRANT;
      RDARB_GRANT: state_d = RDARB_BUSY;
      RDARB_BUSY:  if (pkt_end) state_d = RDARB_IDLE;
      default:     state_d = RDARB_IDLE;
    endcase
  end

  // outputs: the owner's request fields pass to the slave; nothing leaks while idle
  always_comb begin
    memIsFirst       = 1'b0;
    memAddress       = '0;
    memIsDestructive = 1'b0;
    rspIsLast        = '0;
    if (state_q != RDARB_IDLE) begin
      memIsFirst       = reqIsFirst[win_q];
      memAddress       = reqAddress[win_q];
      memIsDestructive = reqIsDestructive[win_q];
    end
    if (pkt_end) begin
      rspIsLast[win_q] = 1'b1;
    end
  end

  assign reqGrant     = grant_q;
  assign rspData      = memData;
  assign rspByteCount = memByteCount;

  // grant, winner index and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q  <= '0;
      win_q    <= '0;
      rr_ptr_q <= '0;
    end else if (take_grant) begin
      grant_q <= pick_one_hot;
      win_q   <= pick_index;
    end else if (pkt_end) begin
      grant_q  <= '0;
      rr_ptr_q <= next_ptr;
    end
  end

`ifdef PAYLOAD_RD_ARB_WDOG_EN
  localparam int CNT_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;

  logic [CNT_W-1:0] wdog_cnt_q;
  logic             wdog_err_q;

  // Loaded with WDOG_CYCLES-1 at grant so terminal count lands on the
  // WDOG_CYCLES-th BUSY cycle; the GRANT cycle does not count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_cnt_q <= '0;
      wdog_err_q <= 1'b0;
    end else begin
      if (take_grant) begin
        wdog_cnt_q <= CNT_W'(WDOG_CYCLES - 1);
      end else if ((state_q == RDARB_BUSY) && (wdog_cnt_q != '0)) begin
        wdog_cnt_q <= wdog_cnt_q - CNT_W'(1);
      end
      if (wdog_expire) begin
        wdog_err_q <= 1'b1;
      end
    end
  end

  assign wdog_expire = (state_q == RDARB_BUSY) && (wdog_cnt_q == '0) && !memIsLast;
  assign wdogErr     = wdog_err_q;
`else
  assign wdog_expire = 1'b0;
  assign wdogErr     = 1'b0;
`endif

endmodule

// File: tb/tb_payload_rd_arbiter.sv
// Directed bench for payload_rd_arbiter (NUM_REQ=4, WDOG_CYCLES=16).
// Client i drives address i*0x100 + row; destructive pattern is fixed.
module tb_payload_rd_arbiter;
  import payload_rd_arbiter_pkg::*;

  localparam int NUM_REQ = 4;
  localparam logic [3:0] DESTR = 4'b0110;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ-1:0]     req_is_first;
  Address_t [NUM_REQ-1:0] req_address;
  logic [NUM_REQ-1:0]     req_is_destructive;
  logic [NUM_REQ-1:0]     req_grant;
  Data_t                  rsp_data;
  ByteCount_t             rsp_byte_count;
  logic [NUM_REQ-1:0]     rsp_is_last;
  logic                   mem_is_first;
  Address_t               mem_address;
  logic                   mem_is_destructive;
  Data_t                  mem_data;
  ByteCount_t             mem_byte_count;
  logic                   mem_is_last;
  logic                   wdog_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  payload_rd_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .WDOG_CYCLES (16)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .reqValid         (req_valid),
    .reqIsFirst       (req_is_first),
    .reqAddress       (req_address),
    .reqIsDestructive (req_is_destructive),
    .reqGrant         (req_grant),
    .rspData          (rsp_data),
    .rspByteCount     (rsp_byte_count),
    .rspIsLast        (rsp_is_last),
    .memIsFirst       (mem_is_first),
    .memAddress       (mem_address),
    .memIsDestructive (mem_is_destructive),
    .memData          (mem_data),
    .memByteCount     (mem_byte_count),
    .memIsLast        (mem_is_last),
    .wdogErr          (wdog_err)
  );

  typedef struct {
    logic       rst;
    logic [3:0] v;
    logic [3:0] f;
    logic       l;
    logic [3:0] g;
    logic [3:0] rl;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst, input logic [3:0] v, input logic [3:0] f,
                     input logic l, input logic [3:0] g, input logic [3:0] rl);
    vec_t r;
    r.rst = rst; r.v = v; r.f = f; r.l = l; r.g = g; r.rl = rl;
    tbl.push_back(r);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int oh_idx(input logic [3:0] oh);
    for (int i = 0; i < 4; i++) if (oh[i]) return i;
    return 0;
  endfunction

  task automatic drive(input logic [3:0] v, input logic [3:0] f, input logic l, input int k);
    req_valid    = v;
    req_is_first = f;
    mem_is_last  = l;
    for (int i = 0; i < NUM_REQ; i++) req_address[i] = Address_t'(i * 256 + k);
    mem_data       = {$urandom, $urandom};
    mem_byte_count = ByteCount_t'($urandom_range(0, 15));
  endtask

  // Ends on a falling edge with reset released and inputs idle.
  task automatic reset_dut();
    rst_n = 1'b0;
    drive(4'b0000, 4'b0000, 1'b0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout bench did not finish");
    $fatal(1);
  end

  initial begin
    int w;
    logic [63:0] exp_addr;
    req_is_destructive = DESTR;

    // reset state with everything asserted on the inputs
    rst_n = 1'b0;
    drive(4'b1111, 4'b1111, 1'b1, 7);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst grant", req_grant, 0);
    check("rst memIsFirst", mem_is_first, 0);
    check("rst memAddress", mem_address, 0);
    check("rst memIsDestructive", mem_is_destructive, 0);
    check("rst rspIsLast", rsp_is_last, 0);
    check("rst wdogErr", wdog_err, 0);
    check("rst rspData", rsp_data, mem_data);
    reset_dut();

    //   rst   valid    first    last  grant    rspIsLast
    // single requester, 4 beats; then rrPtr=1 steers 0011 to client 1
    add(0, 4'b0001, 4'b0000, 0, 4'b0000, 4'b0000);
    add(0, 4'b0001, 4'b0001, 0, 4'b0001, 4'b0000);
    add(0, 4'b0001, 4'b0000, 0, 4'b0001, 4'b0000);
    add(0, 4'b0001, 4'b0000, 0, 4'b0001, 4'b0000);
    add(0, 4'b0000, 4'b0000, 1, 4'b0001, 4'b0001);
    add(0, 4'b0011, 4'b0000, 0, 4'b0000, 4'b0000);
    add(0, 4'b0011, 4'b0010, 1, 4'b0010, 4'b0000); // isLast in GRANT ignored
    add(0, 4'b0001, 4'b0000, 1, 4'b0010, 4'b0010);
    add(0, 4'b0001, 4'b0000, 0, 4'b0000, 4'b0000); // ptr=2 wraps to client 0
    add(0, 4'b0001, 4'b0001, 0, 4'b0001, 4'b0000);
    add(0, 4'b0000, 4'b0000, 1, 4'b0001, 4'b0001);
    add(0, 4'b0000, 4'b0000, 1, 4'b0000, 4'b0000); // isLast in IDLE ignored
    add(0, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000);
    // all four requesting, 2-beat packets: 0,1,2,3,0
    add(1, 4'b1111, 4'b0000, 0, 4'b0000, 4'b0000);
    add(0, 4'b1111, 4'b1111, 0, 4'b0001, 4'b0000);
    add(0, 4'b1111, 4'b0000, 1, 4'b0001, 4'b0001);
    add(0, 4'b1111, 4'b0000, 0, 4'b0000, 4'b0000);
    add(0, 4'b1111, 4'b1111, 0, 4'b0010, 4'b0000);
    add(0, 4'b1111, 4'b0000, 1, 4'b0010, 4'b0010);
    add(0, 4'b1111, 4'b0000, 0, 4'b0000, 4'b0000);
    add(0, 4'b1111, 4'b1111, 0, 4'b0100, 4'b0000);
    add(0, 4'b1111, 4'b0000, 1, 4'b0100, 4'b0100);
    add(0, 4'b1111, 4'b0000, 0, 4'b0000, 4'b0000);
    add(0, 4'b1111, 4'b1111, 0, 4'b1000, 4'b0000);
    add(0, 4'b1111, 4'b0000, 1, 4'b1000, 4'b1000);
    add(0, 4'b1111, 4'b0000, 0, 4'b0000, 4'b0000);
    add(0, 4'b1111, 4'b1111, 0, 4'b0001, 4'b0000);
    add(0, 4'b0000, 4'b0000, 1, 4'b0001, 4'b0001);
    add(0, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000);
    // fairness: client 0 always requesting, client 2 joins during packet 0
    add(1, 4'b0001, 4'b0000, 0, 4'b0000, 4'b0000);
    add(0, 4'b0001, 4'b0001, 0, 4'b0001, 4'b0000);
    add(0, 4'b0101, 4'b0000, 1, 4'b0001, 4'b0001);
    add(0, 4'b0101, 4'b0000, 0, 4'b0000, 4'b0000);
    add(0, 4'b0101, 4'b0100, 0, 4'b0100, 4'b0000);
    add(0, 4'b0101, 4'b0000, 1, 4'b0100, 4'b0100);
    add(0, 4'b0101, 4'b0000, 0, 4'b0000, 4'b0000);
    add(0, 4'b0101, 4'b0001, 0, 4'b0001, 4'b0000);
    add(0, 4'b0101, 4'b0000, 1, 4'b0001, 4'b0001);
    add(0, 4'b0101, 4'b0000, 0, 4'b0000, 4'b0000);
    add(0, 4'b0001, 4'b0100, 0, 4'b0100, 4'b0000);
    add(0, 4'b0001, 4'b0000, 1, 4'b0100, 4'b0100);
    add(0, 4'b0001, 4'b0000, 0, 4'b0000, 4'b0000);
    // winner drops reqValid after beat 1 of 3; client 2 waits, sees no isLast
    add(0, 4'b0001, 4'b0001, 0, 4'b0001, 4'b0000);
    add(0, 4'b0100, 4'b0000, 0, 4'b0001, 4'b0000);
    add(0, 4'b0100, 4'b0100, 1, 4'b0001, 4'b0001);
    add(0, 4'b0100, 4'b0000, 0, 4'b0000, 4'b0000);
    add(0, 4'b0000, 4'b0100, 0, 4'b0100, 4'b0000);
    add(0, 4'b0000, 4'b0000, 1, 4'b0100, 4'b0100);
    add(0, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000);

    for (int k = 0; k < tbl.size(); k++) begin
      if (tbl[k].rst) reset_dut();
      step();
      drive(tbl[k].v, tbl[k].f, tbl[k].l, k);
      @(negedge clk);
      w = oh_idx(tbl[k].g);
      exp_addr = (tbl[k].g != 0) ? 64'(w * 256 + k) : 64'd0;
      check($sformatf("row%0d grant", k), req_grant, tbl[k].g);
      check($sformatf("row%0d rspIsLast", k), rsp_is_last, tbl[k].rl);
      check($sformatf("row%0d memIsFirst", k), mem_is_first,
            (tbl[k].g != 0) ? tbl[k].f[w] : 1'b0);
      check($sformatf("row%0d memAddress", k), mem_address, exp_addr);
      check($sformatf("row%0d memIsDestructive", k), mem_is_destructive,
            (tbl[k].g != 0) ? DESTR[w] : 1'b0);
      check($sformatf("row%0d rspData", k), rsp_data, mem_data);
      check($sformatf("row%0d rspByteCount", k), rsp_byte_count, mem_byte_count);
      check($sformatf("row%0d wdogErr", k), wdog_err, 0);
    end

    // reset during BUSY beat 2: outputs drop without a clock edge
    reset_dut();
    step(); drive(4'b0001, 4'b0000, 1'b0, 1);
    @(negedge clk); check("rstmid idle grant", req_grant, 0);
    step(); drive(4'b0001, 4'b0001, 1'b0, 2);
    @(negedge clk); check("rstmid grant", req_grant, 4'b0001);
    step(); drive(4'b0001, 4'b0001, 1'b1, 3);
    @(negedge clk);
    check("rstmid busy memIsFirst", mem_is_first, 1);
    check("rstmid busy rspIsLast", rsp_is_last, 4'b0001);
    #1 rst_n = 1'b0;
    #1;
    check("rstmid async grant", req_grant, 0);
    check("rstmid async memIsFirst", mem_is_first, 0);
    check("rstmid async memAddress", mem_address, 0);
    check("rstmid async memIsDestructive", mem_is_destructive, 0);
    check("rstmid async rspIsLast", rsp_is_last, 0);
    drive(4'b0010, 4'b0000, 1'b0, 4);
    @(negedge clk); rst_n = 1'b1;
    step();
    @(negedge clk); check("rstmid regrant", req_grant, 4'b0010);

    // watchdog: slave never returns isLast
    reset_dut();
    step(); drive(4'b0011, 4'b0000, 1'b0, 5);
    @(negedge clk); check("wdog idle grant", req_grant, 0);
    step(); drive(4'b0011, 4'b0001, 1'b0, 6);
    @(negedge clk); check("wdog grant", req_grant, 4'b0001);
`ifdef PAYLOAD_RD_ARB_WDOG_EN
    for (int c = 1; c <= 16; c++) begin
      step(); drive(4'b0011, 4'b0000, 1'b0, 6 + c);
      @(negedge clk);
      check($sformatf("wdog busy%0d grant", c), req_grant, 4'b0001);
      check($sformatf("wdog busy%0d rspIsLast", c), rsp_is_last,
            (c == 16) ? 4'b0001 : 4'b0000);
      check($sformatf("wdog busy%0d wdogErr", c), wdog_err, 0);
    end
    step();
    @(negedge clk);
    check("wdog released grant", req_grant, 0);
    check("wdog err set", wdog_err, 1);
    check("wdog released rspIsLast", rsp_is_last, 0);
    step();
    @(negedge clk);
    check("wdog next grant", req_grant, 4'b0010);
    check("wdog err sticky", wdog_err, 1);
`else
    for (int c = 1; c <= 40; c++) begin
      step(); drive(4'b0011, 4'b0000, 1'b0, 6 + c);
      @(negedge clk);
      check($sformatf("nowdog busy%0d grant", c), req_grant, 4'b0001);
      check($sformatf("nowdog busy%0d rspIsLast", c), rsp_is_last, 0);
      check($sformatf("nowdog busy%0d wdogErr", c), wdog_err, 0);
    end
    step(); drive(4'b0011, 4'b0000, 1'b1, 50);
    @(negedge clk);
    check("nowdog end rspIsLast", rsp_is_last, 4'b0001);
    step(); drive(4'b0011, 4'b0000, 1'b0, 51);
    @(negedge clk);
    check("nowdog released grant", req_grant, 0);
    step();
    @(negedge clk);
    check("nowdog next grant", req_grant, 4'b0010);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
